arith_seq_unit: RTL and testbench

Multi-function sequential integer arithmetic unit: unsigned add with carry-out detection, iterative factorial, and greatest common factor (Euclid by subtraction). One operation runs at a time under a start/done handshake. Shared N-bit datapath. Sits as a small compute co-processor behind a control FSM or register interface.

---
 rtl/arith_seq_pkg.sv | 18 +
 rtl/arith_mul_trunc.sv | 19 +
 rtl/arith_seq_unit.sv | 156 +++++++++++++++
 tb/tb_arith_seq_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_seq_pkg.sv
// Shared types for the sequential arithmetic unit: operation codes and FSM states.
package arith_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_FACT = 2'b01,
    OP_GCF  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    FACT,
    GCF
  } state_e;

endpackage

// File: rtl/arith_mul_trunc.sv
// N x N unsigned multiply: low N bits of the product plus a flag for any nonzero upper bit.
module arith_mul_trunc #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] lo,
  output logic         ovf
);

  logic [2*N-1:0] prod;

  always_comb begin
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    lo   = prod[N-1:0];
    ovf  = |prod[2*N-1:N];
  end

endmodule

// File: rtl/arith_seq_unit.sv
// Sequential arithmetic co-processor: add/carry, iterative factorial and subtractive GCF
// sharing one pair of N-bit working registers under a start/done handshake.
module arith_seq_unit
  import arith_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] res,
  output logic         flag
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_nx;
  op_e          op_q, op_nx;
  // x holds the accumulator (FACT) or first GCF operand; y holds the count or second operand
  logic [N-1:0] x_q, x_nx;
  logic [N-1:0] y_q, y_nx;
  logic         ovf_q, ovf_nx;
  logic [N-1:0] res_q, res_nx;
  logic         flag_q, flag_nx;
  logic         done_q, done_nx;
  logic         busy_q, busy_nx;

  logic [N:0]   sum;
  logic [N-1:0] mul_lo;
  logic         mul_ovf;

  arith_mul_trunc #(.N(N)) u_mul (
    .a   (x_q),
    .b   (y_q),
    .lo  (mul_lo),
    .ovf (mul_ovf)
  );

  always_comb begin
    state_nx = state_q;
    op_nx    = op_q;
    x_nx     = x_q;
    y_nx     = y_q;
    ovf_nx   = ovf_q;
    res_nx   = res_q;
    flag_nx  = flag_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    sum      = {1'b0, x_q} + {1'b0, y_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_nx   = op_e'(op);
          x_nx    = a;
          y_nx    = b;
          ovf_nx  = 1'b0;
          busy_nx = 1'b1;
          case (op_e'(op))
            OP_FACT: begin
              x_nx     = ONE;
              y_nx     = a;
              state_nx = FACT;
            end
            OP_GCF:  state_nx = GCF;
            default: state_nx = ADD;  // reserved op shares the single-cycle path
          endcase
        end
      end

      ADD: begin
        if (op_q == OP_RSVD) begin
          res_nx  = '0;
          flag_nx = 1'b1;
        end else begin
          res_nx  = sum[N-1:0];
          flag_nx = sum[N];
        end
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      FACT: begin
        if (y_q <= ONE) begin
          res_nx   = x_q;
          flag_nx  = ovf_q;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          x_nx   = mul_lo;
          ovf_nx = ovf_q | mul_ovf;
          y_nx   = y_q - ONE;
        end
      end

      GCF: begin
        if (y_q == '0 || x_q == y_q) begin
          res_nx   = x_q;
          flag_nx  = 1'b0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else if (x_q == '0) begin
          res_nx   = y_q;
          flag_nx  = 1'b0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else if (x_q > y_q) begin
          x_nx = x_q - y_q;
        end else begin
          y_nx = y_q - x_q;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      x_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      op_q    <= op_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      ovf_q   <= ovf_nx;
      res_q   <= res_nx;
      flag_q  <= flag_nx;
      done_q  <= done_nx;
      busy_q  <= busy_nx;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign flag = flag_q;

endmodule

// File: tb/tb_arith_seq_unit.sv
// Scoreboard bench for arith_seq_unit: each operation pushes its expected result and latency,
// which is popped and compared when done is seen.
module tb_arith_seq_unit;
  localparam int N     = 16;
  localparam int LIMIT = 2000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] res;
  logic         flag;

  arith_seq_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .flag  (flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         flag;
    int           lat;
    string        name;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  // Called at posedge+1 with the DUT idle (or in its done cycle); returns at posedge+1 after acceptance.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb,
                       input logic [N-1:0] er, input logic ef, input int el, input string nm);
    exp_t e;
    e.res = er; e.flag = ef; e.lat = el; e.name = nm;
    sb.push_back(e);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); op = 2'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= LIMIT; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, res, flag} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b res=%h flag=%b, expected all 0", busy, done, res, flag);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [N-1:0] va[4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF};
    logic [N-1:0] vb[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000};
    int lat;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      logic [N:0] s;
      s = {1'b0, va[i]} + {1'b0, vb[i]};
      issue(2'b00, va[i], vb[i], s[N-1:0], s[N], 1, $sformatf("add%0d", i));
      if (i == 0) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL add_busy: busy=%b, expected 1", busy);
        end
      end
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat < 0 || res !== e.res || flag !== e.flag || lat != e.lat || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s: res=%h flag=%b lat=%0d busy=%b, expected res=%h flag=%b lat=%0d busy=0",
                 e.name, res, flag, lat, busy, e.res, e.flag, e.lat);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || res !== e.res || flag !== e.flag) begin
          tests_failed++;
          $display("FAIL add_hold: done=%b res=%h flag=%b, expected done=0 res=%h flag=%b",
                   done, res, flag, e.res, e.flag);
        end
      end
    end
  endtask

  task automatic test_fact();
    int           vn[6] = '{4, 5, 6, 7, 0, 9};
    logic [N-1:0] vr[6] = '{16'd24, 16'd120, 16'd720, 16'd5040, 16'd1, 16'd35200};
    logic         vf[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int           vl[6] = '{4, 5, 6, 7, 1, 9};
    int lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(2'b01, N'(vn[i]), 16'hABCD, vr[i], vf[i], vl[i], $sformatf("fact_%0d", vn[i]));
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat < 0 || res !== e.res || flag !== e.flag || lat != e.lat) begin
        tests_failed++;
        $display("FAIL %s: res=%0d flag=%b lat=%0d, expected res=%0d flag=%b lat=%0d",
                 e.name, res, flag, lat, e.res, e.flag, e.lat);
      end
    end
  endtask

  task automatic test_gcf();
    logic [N-1:0] va[6] = '{16'd24, 16'd18, 16'd101, 16'd7, 16'd0, 16'd0};
    logic [N-1:0] vb[6] = '{16'd36, 16'd48, 16'd303, 16'd3, 16'd9, 16'd0};
    logic [N-1:0] vr[6] = '{16'd12, 16'd6, 16'd101, 16'd1, 16'd9, 16'd0};
    int           vl[6] = '{3, -1, -1, -1, 1, 1};
    int lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(2'b10, va[i], vb[i], vr[i], 1'b0, vl[i], $sformatf("gcf_%0d_%0d", va[i], vb[i]));
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat < 0 || res !== e.res || flag !== e.flag || (e.lat >= 0 && lat != e.lat)) begin
        tests_failed++;
        $display("FAIL %s: res=%0d flag=%b lat=%0d, expected res=%0d flag=%b lat=%0d (-1 any)",
                 e.name, res, flag, lat, e.res, e.flag, e.lat);
      end
    end
  endtask

  task automatic test_rsvd();
    int lat;
    exp_t e;
    issue(2'b11, 16'd5, 16'd5, 16'd0, 1'b1, 1, "rsvd");
    wait_done(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat < 0 || res !== e.res || flag !== e.flag || lat != e.lat) begin
      tests_failed++;
      $display("FAIL %s: res=%h flag=%b lat=%0d, expected res=%h flag=%b lat=%0d",
               e.name, res, flag, lat, e.res, e.flag, e.lat);
    end
  endtask

  task automatic test_handshake();
    int ndone = 0;
    int lat = -1;
    logic [N-1:0] got_res = '0;
    logic got_flag = 1'b0;
    exp_t e;
    issue(2'b01, 16'd7, 16'd0, 16'd5040, 1'b0, 7, "fact7_ignore_start");
    for (int c = 1; c <= 30; c++) begin
      start = (ndone == 0) ? ~start : 1'b0;
      op = 2'b00; a = 16'd1; b = 16'd1;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
        got_res = res; got_flag = flag;
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if (ndone != 1) begin
      tests_failed++;
      $display("FAIL handshake_done_count: got %0d done pulses, expected 1", ndone);
    end
    tests_run++;
    if (got_res !== e.res || got_flag !== e.flag || lat != e.lat) begin
      tests_failed++;
      $display("FAIL %s: res=%0d flag=%b lat=%0d, expected res=%0d flag=%b lat=%0d",
               e.name, got_res, got_flag, lat, e.res, e.flag, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    issue(2'b00, 16'd1, 16'd2, 16'd3, 1'b0, 1, "b2b_add");
    wait_done(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat < 0 || res !== e.res || flag !== e.flag || lat != e.lat) begin
      tests_failed++;
      $display("FAIL %s: res=%h flag=%b lat=%0d, expected res=%h flag=%b lat=%0d",
               e.name, res, flag, lat, e.res, e.flag, e.lat);
    end
    // still in the done cycle: start here must be taken straight away
    issue(2'b01, 16'd5, 16'd0, 16'd120, 1'b0, 5, "b2b_fact5");
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    wait_done(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat < 0 || res !== e.res || flag !== e.flag || lat != e.lat) begin
      tests_failed++;
      $display("FAIL %s: res=%0d flag=%b lat=%0d, expected res=%0d flag=%b lat=%0d",
               e.name, res, flag, lat, e.res, e.flag, e.lat);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int ndone = 0;
    exp_t e;
    issue(2'b10, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, -1, "gcf_aborted");
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_busy_before: busy=%b, expected 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(sb.pop_front());
    tests_run++;
    if ({busy, done, res, flag} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_state: busy=%b done=%b res=%h flag=%b, expected all 0", busy, done, res, flag);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    tests_run++;
    if (ndone != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_no_done: done pulses=%0d busy=%b, expected 0 and 0", ndone, busy);
    end
    issue(2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1, "add_after_reset");
    wait_done(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat < 0 || res !== e.res || flag !== e.flag || lat != e.lat) begin
      tests_failed++;
      $display("FAIL %s: res=%h flag=%b lat=%0d, expected res=%h flag=%b lat=%0d",
               e.name, res, flag, lat, e.res, e.flag, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fact();
    test_gcf();
    test_rsvd();
    test_handshake();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
